// File: rtl/cavlc_coeff_unscan.sv
// cavlc_coeff_unscan: captures one 16-coefficient residual block in zig-zag
// order, inverse-scans it into raster order and streams it out row by row.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ena               global enable; low freezes all state
//   blk_valid/in_ready  block capture handshake (coeff_0..15, mode)
//   mode              0=4x4, 1=AC (15 coeffs), 2=chroma DC 2x2, 3=as 0
//   out_valid/out_ready row beat handshake
//   out_row/out_last/out_dc  beat row index, final beat, chroma DC flag
//   out_data_0..3     columns 0..3 of the current row
module cavlc_coeff_unscan (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       blk_valid,
    output logic       in_ready,
    input  logic [1:0] mode,
    input  logic [8:0] coeff_0,
    input  logic [8:0] coeff_1,
    input  logic [8:0] coeff_2,
    input  logic [8:0] coeff_3,
    input  logic [8:0] coeff_4,
    input  logic [8:0] coeff_5,
    input  logic [8:0] coeff_6,
    input  logic [8:0] coeff_7,
    input  logic [8:0] coeff_8,
    input  logic [8:0] coeff_9,
    input  logic [8:0] coeff_10,
    input  logic [8:0] coeff_11,
    input  logic [8:0] coeff_12,
    input  logic [8:0] coeff_13,
    input  logic [8:0] coeff_14,
    input  logic [8:0] coeff_15,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_row,
    output logic       out_last,
    output logic       out_dc,
    output logic [8:0] out_data_0,
    output logic [8:0] out_data_1,
    output logic [8:0] out_data_2,
    output logic [8:0] out_data_3
);

    // Scan index -> raster position (row*4+col), frame zig-zag.
    localparam logic [3:0] ZZ [16] = '{
        4'd0,  4'd1,  4'd4,  4'd8,
        4'd5,  4'd2,  4'd3,  4'd6,
        4'd9,  4'd12, 4'd13, 4'd10,
        4'd7,  4'd11, 4'd14, 4'd15
    };

    logic [8:0] r_bank [2][16];
    logic [1:0] r_dc;
    logic       r_wp;
    logic       r_rp;
    logic [1:0] r_cnt;
    logic [1:0] r_row;

    logic [8:0] w_cin    [16];
    logic [8:0] w_raster [16];
    logic       w_is_dc;
    logic       w_cap;
    logic       w_beat;
    logic       w_last;

    always_comb begin
        w_cin = '{coeff_0,  coeff_1,  coeff_2,  coeff_3,
                  coeff_4,  coeff_5,  coeff_6,  coeff_7,
                  coeff_8,  coeff_9,  coeff_10, coeff_11,
                  coeff_12, coeff_13, coeff_14, coeff_15};
        w_raster = '{default: '0};
        w_is_dc  = 1'b0;
        case (mode)
            2'd2: begin
                // Chroma DC 2x2 is already in raster order.
                w_is_dc = 1'b1;
                for (int i = 0; i < 4; i++)
                    w_raster[i] = w_cin[i];
            end
            2'd1: begin
                // AC block: coefficients start at scan position 1.
                for (int p = 1; p < 16; p++)
                    w_raster[ZZ[p]] = w_cin[p-1];
            end
            default: begin
                for (int s = 0; s < 16; s++)
                    w_raster[ZZ[s]] = w_cin[s];
            end
        endcase
    end

    assign in_ready  = (r_cnt != 2'd2);
    assign out_valid = (r_cnt != 2'd0);
    assign w_cap     = blk_valid & in_ready & ena;
    assign w_beat    = out_valid & out_ready & ena;
    assign w_last    = r_dc[r_rp] | (r_row == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank <= '{default: '{default: '0}};
            r_dc   <= '0;
            r_wp   <= 1'b0;
            r_rp   <= 1'b0;
            r_cnt  <= 2'd0;
            r_row  <= 2'd0;
        end else if (ena) begin
            if (w_cap) begin
                r_bank[r_wp] <= w_raster;
                r_dc[r_wp]   <= w_is_dc;
                r_wp         <= ~r_wp;
            end
            if (w_beat) begin
                if (w_last) begin
                    r_row <= 2'd0;
                    r_rp  <= ~r_rp;
                end else begin
                    r_row <= r_row + 2'd1;
                end
            end
            case ({w_cap, w_beat & w_last})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Outputs are forced to zero while nothing is buffered.
    assign out_row    = r_row;
    assign out_last   = out_valid & w_last;
    assign out_dc     = out_valid & r_dc[r_rp];
    assign out_data_0 = out_valid ? r_bank[r_rp][{r_row, 2'd0}] : '0;
    assign out_data_1 = out_valid ? r_bank[r_rp][{r_row, 2'd1}] : '0;
    assign out_data_2 = out_valid ? r_bank[r_rp][{r_row, 2'd2}] : '0;
    assign out_data_3 = out_valid ? r_bank[r_rp][{r_row, 2'd3}] : '0;

endmodule

// File: tb/tb_cavlc_coeff_unscan.sv
// tb_cavlc_coeff_unscan: directed checks of capture, inverse scan,
// double buffering, backpressure, reset and enable behaviour.
module tb_cavlc_coeff_unscan;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       blk_valid;
    logic       in_ready;
    logic [1:0] mode;
    logic [8:0] c [16];
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_row;
    logic       out_last;
    logic       out_dc;
    logic [8:0] out_data_0;
    logic [8:0] out_data_1;
    logic [8:0] out_data_2;
    logic [8:0] out_data_3;

    int nerr = 0;
    int nchk = 0;

    // Hand-computed raster rows for coeff_k = k+1.
    int M0 [16] = '{1, 2, 6, 7,   3, 5, 8, 13,
                    4, 9, 12, 14, 10, 11, 15, 16};
    int M1 [16] = '{0, 1, 5, 6,   2, 4, 7, 12,
                    3, 8, 11, 13, 9, 10, 14, 15};

    always #5 clk = ~clk;

    cavlc_coeff_unscan dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .blk_valid(blk_valid), .in_ready(in_ready), .mode(mode),
        .coeff_0(c[0]),   .coeff_1(c[1]),   .coeff_2(c[2]),
        .coeff_3(c[3]),   .coeff_4(c[4]),   .coeff_5(c[5]),
        .coeff_6(c[6]),   .coeff_7(c[7]),   .coeff_8(c[8]),
        .coeff_9(c[9]),   .coeff_10(c[10]), .coeff_11(c[11]),
        .coeff_12(c[12]), .coeff_13(c[13]), .coeff_14(c[14]),
        .coeff_15(c[15]),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_last(out_last), .out_dc(out_dc),
        .out_data_0(out_data_0), .out_data_1(out_data_1),
        .out_data_2(out_data_2), .out_data_3(out_data_3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [40:0] beat(input logic v, input int r,
            input logic l, input logic d,
            input int a, input int b, input int e, input int f);
        logic [8:0] x0, x1, x2, x3;
        logic [1:0] rr;
        x0 = a[8:0]; x1 = b[8:0]; x2 = e[8:0]; x3 = f[8:0];
        rr = r[1:0];
        return {v, rr, l, d, x0, x1, x2, x3};
    endfunction

    function automatic logic [40:0] obs_beat();
        return {out_valid, out_row, out_last, out_dc,
                out_data_0, out_data_1, out_data_2, out_data_3};
    endfunction

    function automatic logic [40:0] m0row(input int r, input int off);
        return beat(1'b1, r, r == 3, 1'b0,
                    M0[r*4] + off, M0[r*4+1] + off,
                    M0[r*4+2] + off, M0[r*4+3] + off);
    endfunction

    function automatic logic [40:0] m1row(input int r);
        return beat(1'b1, r, r == 3, 1'b0,
                    M1[r*4], M1[r*4+1], M1[r*4+2], M1[r*4+3]);
    endfunction

    task automatic set_coeffs(input int base, input logic [1:0] m);
        for (int k = 0; k < 16; k++) c[k] = 9'(base + k);
        mode = m;
    endtask

    task automatic set_dc(input int a, input int b, input int e,
                          input int f);
        set_coeffs(50, 2'd2);
        c[0] = a[8:0]; c[1] = b[8:0]; c[2] = e[8:0]; c[3] = f[8:0];
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; blk_valid = 1'b0; out_ready = 1'b0;
        set_coeffs(1, 2'd0);
        step(); step();
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out", 64'(obs_beat()), 64'(beat(0, 0, 0, 0, 0, 0, 0, 0)));
        rst_n = 1'b1;
        step();

        // 4x4 block, mode 0
        set_coeffs(1, 2'd0); blk_valid = 1'b1;
        step();
        blk_valid = 1'b0;
        chk("m0_row0", 64'(obs_beat()), 64'(m0row(0, 0)));
        step();
        chk("m0_hold", 64'(obs_beat()), 64'(m0row(0, 0)));
        out_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            chk($sformatf("m0_row%0d", r), 64'(obs_beat()), 64'(m0row(r, 0)));
            step();
        end
        chk("m0_empty", 64'(out_valid), 64'd0);

        // AC block, mode 1 (coeff_15 must be ignored)
        set_coeffs(1, 2'd1); blk_valid = 1'b1;
        step();
        blk_valid = 1'b0;
        for (int r = 0; r < 4; r++) begin
            chk($sformatf("m1_row%0d", r), 64'(obs_beat()), 64'(m1row(r)));
            step();
        end

        // Chroma DC, mode 2
        set_dc(-1, 2, -3, 4); blk_valid = 1'b1;
        step();
        blk_valid = 1'b0;
        chk("dc_beat", 64'(obs_beat()), 64'(beat(1, 0, 1, 1, -1, 2, -3, 4)));
        step();
        chk("dc_done", 64'(out_valid), 64'd0);

        // Backpressure: A and B fill both banks, C must wait
        out_ready = 1'b0;
        set_coeffs(1, 2'd0); blk_valid = 1'b1;
        step();
        set_coeffs(20, 2'd0);
        step();
        chk("bp_full", 64'(in_ready), 64'd0);
        set_dc(5, 6, 7, 8);
        step(); step();
        chk("bp_held", 64'(in_ready), 64'd0);
        chk("bp_a_row0", 64'(obs_beat()), 64'(m0row(0, 0)));
        out_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            chk($sformatf("bp_a_row%0d", r), 64'(obs_beat()), 64'(m0row(r, 0)));
            step();
        end
        chk("bp_ready_back", 64'(in_ready), 64'd1);
        chk("bp_b_row0", 64'(obs_beat()), 64'(m0row(0, 19)));
        step();
        blk_valid = 1'b0;
        chk("bp_c_taken", 64'(in_ready), 64'd0);
        for (int r = 1; r < 4; r++) begin
            chk($sformatf("bp_b_row%0d", r), 64'(obs_beat()), 64'(m0row(r, 19)));
            step();
        end
        chk("bp_c_ready", 64'(in_ready), 64'd1);
        chk("bp_c_beat", 64'(obs_beat()), 64'(beat(1, 0, 1, 1, 5, 6, 7, 8)));
        step();
        chk("bp_empty", 64'(out_valid), 64'd0);

        // Capture coinciding with the last beat, continuous out_ready
        set_coeffs(1, 2'd0); blk_valid = 1'b1;
        step();
        blk_valid = 1'b0;
        for (int r = 0; r < 4; r++) begin
            chk($sformatf("b2b_x_row%0d", r), 64'(obs_beat()), 64'(m0row(r, 0)));
            if (r == 3) begin set_coeffs(1, 2'd1); blk_valid = 1'b1; end
            step();
            blk_valid = 1'b0;
        end
        chk("b2b_ready", 64'(in_ready), 64'd1);
        for (int r = 0; r < 4; r++) begin
            chk($sformatf("b2b_y_row%0d", r), 64'(obs_beat()), 64'(m1row(r)));
            if (r == 3) begin set_coeffs(20, 2'd3); blk_valid = 1'b1; end
            step();
            blk_valid = 1'b0;
        end
        for (int r = 0; r < 4; r++) begin
            chk($sformatf("b2b_z_row%0d", r), 64'(obs_beat()), 64'(m0row(r, 19)));
            step();
        end
        chk("b2b_empty", 64'(out_valid), 64'd0);

        // Reset mid-drain of row 2
        set_coeffs(1, 2'd0); blk_valid = 1'b1;
        step();
        blk_valid = 1'b0;
        step(); step();
        chk("rst_row2", 64'(obs_beat()), 64'(m0row(2, 0)));
        rst_n = 1'b0;
        step();
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_out", 64'(obs_beat()), 64'(beat(0, 0, 0, 0, 0, 0, 0, 0)));
        rst_n = 1'b1;
        step();

        // ena low freezes stream and blocks capture
        set_coeffs(1, 2'd0); blk_valid = 1'b1;
        step();
        blk_valid = 1'b0;
        step();
        chk("ena_row1", 64'(obs_beat()), 64'(m0row(1, 0)));
        ena = 1'b0;
        set_coeffs(1, 2'd1); blk_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("ena_frozen%0d", i), 64'(obs_beat()), 64'(m0row(1, 0)));
        end
        ena = 1'b1; blk_valid = 1'b0;
        step();
        chk("ena_row2", 64'(obs_beat()), 64'(m0row(2, 0)));
        step();
        chk("ena_row3", 64'(obs_beat()), 64'(m0row(3, 0)));
        step();
        chk("ena_no_capture", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/cavlc_coeff_unscan.md
# cavlc_coeff_unscan

Downstream of the CAVLC run_before stage: captures the 16 zig-zag-ordered 9-bit coefficients the run_before stage produces for one residual block, applies inverse zig-zag (frame) scan, and streams the block out row by row to the inverse-quant/transform path. Two banks double-buffer the data so the CAVLC decoder can start the next block while the previous one drains.

## Interface
Parameters:
- none (coefficient width fixed at 9, block fixed at 4x4)

Ports:
- `clk`  in  1  system clock, all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `ena`  in  1  global enable; when low, no state changes (capture, counters, banks frozen); outputs hold
- `blk_valid`  in  1  a complete block is present on `coeff_0..coeff_15`/`mode`
- `in_ready`  out  1  capture bank available; transfer when `blk_valid && in_ready && ena`
- `mode`  in  2  0 = 4x4 (16 coeffs), 1 = AC (15 coeffs, `coeff_k` goes to scan position k+1, position 0 forced 0), 2 = chroma DC 2x2, 3 = reserved (treated as 0)
- `coeff_0 .. coeff_15`  in  9 each  two's-complement coefficients in scan order
- `out_valid`  out  1  a row is presented
- `out_ready`  in  1  downstream accepts; beat transfers when `out_valid && out_ready && ena`
- `out_row`  out  2  row index of current beat (0..3)
- `out_last`  out  1  final beat of block
- `out_dc`  out  1  current block is chroma DC
- `out_data_0 .. out_data_3`  out  9 each  columns 0..3 of the row

## Operation
- Inverse scan, scan index -> raster position (row*4+col): 0->0, 1->1, 2->4, 3->8, 4->5, 5->2, 6->3, 7->6, 8->9, 9->12, 10->13, 11->10, 12->7, 13->11, 14->14, 15->15. Applied at capture; banks store raster order.
- Mode 1: scan position p (1..15) takes `coeff_{p-1}`; `coeff_15` ignored; raster 0 = 0.
- Mode 2: raster 0..3 = `coeff_0..coeff_3` unchanged; remaining entries 0; block is one beat (`out_row`=0, `out_last`=1, `out_dc`=1).
- Modes 0/1/3: four beats, rows 0,1,2,3; `out_last` on row 3; `out_dc`=0.
- State: two banks (16x9 + mode bit each), write pointer `wp`, read pointer `rp`, occupancy `cnt` 0..2, row counter `row` 0..3.
- `in_ready` = (`cnt` != 2); depends only on registered state, no path from `out_ready`.
- `out_valid` = (`cnt` != 0). `out_data_*`, `out_row`, `out_last`, `out_dc` decode from bank `rp` and `row`; stable while `out_valid && !out_ready`.
- Capture: write bank `wp`, toggle `wp`, `cnt`+1.
- Beat accepted: `row`+1; if last beat, `row`<=0, toggle `rp`, `cnt`-1.
- Capture and last-beat in same cycle: `cnt` unchanged, both pointers toggle.
- Values pass through unmodified (no saturation, no sign change).

## Timing
- Reset (async, `rst_n`=0): `wp`=`rp`=0, `cnt`=0, `row`=0 -> `in_ready`=1, `out_valid`=0, `out_row`=0, `out_last`=0, `out_dc`=0, `out_data_*`=0 (banks cleared). Reset mid-block discards both banks.
- Latency: capture in cycle N into empty buffer -> `out_valid`=1 with row 0 in N+1.
- Throughput: one beat/cycle with `out_ready` high; 4x4 block drains in 4 cycles, DC in 1; with both banks full `in_ready` returns 1 the cycle after the last beat is accepted.
- `blk_valid` while `in_ready`=0: ignored, no capture; upstream must hold.
- `ena`=0: handshakes not counted even if valid/ready high.

## Test plan
- Reset then 4x4 block `coeff_k`=k+1, mode 0 -> cycle after capture rows: {1,2,6,7}, {3,5,8,13}, {4,9,12,14}, {10,11,15,16}; `out_last` only on row 3.
- Mode 1, `coeff_k`=k+1 -> row 0 = {0,1,5,6}, row 3 = {9,10,14,15}.
- Mode 2, `coeff_0..3`={-1,2,-3,4} (9'h1FF,...) -> single beat {-1,2,-3,4}, `out_dc`=1, `out_last`=1.
- `out_ready`=0, capture blocks A, B -> `in_ready`=0, block C held and not captured; release -> A rows then B rows, C captured the cycle after A's last beat is accepted.
- Back-to-back capture coinciding with last beat, continuous `out_ready` -> `cnt` stays 1, gap-free row stream, no lost/duplicated block.
- Assert `rst_n`=0 mid-drain of row 2 -> next cycle `out_valid`=0, `in_ready`=1, outputs 0; `ena`=0 for 3 cycles mid-stream -> row index and data frozen.
